// File: rtl/adder_pkg.sv
// Shared definitions for the narrow adder slice and its multi-word operand sequencer.
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } adder_state_e;

  localparam int unsigned ADDER_WIDTH_DEF = 4;
  localparam int unsigned ADDER_LAT_COMB  = 0;
  localparam int unsigned ADDER_LAT_PIPE  = 1;

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Operand, adder-slice and result signals of multiword_add_sequencer.
// res_ovf exists only when MWAS_SIGNED_OVF_EN is defined.
interface multiword_add_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WORDS = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WORDS*WIDTH-1:0] op_a;
  logic [WORDS*WIDTH-1:0] op_b;
  logic                   op_cin;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic                   add_cin;
  logic [WIDTH-1:0]       add_sum;
  logic                   add_cout;
  logic                   res_valid;
  logic                   res_ready;
  logic [WORDS*WIDTH-1:0] result;
  logic                   res_cout;
`ifdef MWAS_SIGNED_OVF_EN
  logic                   res_ovf;
`endif

  // Sequencer side.
  modport slave (
    input  in_valid, op_a, op_b, op_cin, add_sum, add_cout, res_ready,
    output in_ready, add_a, add_b, add_cin, res_valid, result, res_cout
`ifdef MWAS_SIGNED_OVF_EN
    , output res_ovf
`endif
  );

  // Environment side: operand producer, adder slice and result consumer.
  modport master (
    output in_valid, op_a, op_b, op_cin, add_sum, add_cout, res_ready,
    input  in_ready, add_a, add_b, add_cin, res_valid, result, res_cout
`ifdef MWAS_SIGNED_OVF_EN
    , input res_ovf
`endif
  );

endinterface

// File: rtl/full_half_adder.sv
// WIDTH-bit adder slice with carry in/out; LAT=0 is combinational, otherwise one register stage.
module full_half_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH_DEF,
  parameter int unsigned LAT   = ADDER_LAT_COMB
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

  if (LAT == 0) begin : g_comb
    assign {cout_o, sum_o} = full;
  end else begin : g_pipe
    logic [WIDTH:0] full_q;
    always_ff @(posedge clk) begin
      full_q <= full;
    end
    assign {cout_o, sum_o} = full_q;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Feeds WORDS*WIDTH-bit operands LSW-first through a narrow adder, rippling carry between slices.
// Define MWAS_SIGNED_OVF_EN to add the registered two's-complement overflow output res_ovf.
module multiword_add_sequencer
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH   = ADDER_WIDTH_DEF,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned ADD_LAT = ADDER_LAT_COMB
) (
  input logic                      clk,
  input logic                      rst,
  multiword_add_sequencer_if.slave bus
);

  localparam int unsigned TotW = WORDS * WIDTH;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CntW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  adder_state_e    state_q, state_d;
  logic [TotW-1:0] a_q, a_d, b_q, b_d;
  logic [TotW-1:0] result_q, result_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
`ifdef MWAS_SIGNED_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
`ifdef MWAS_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;

    case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          carry_d = bus.op_cin;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Slice inputs stay put for all ADD_LAT+1 cycles of the slice.
        bus.add_a   = a_q[idx_q*WIDTH +: WIDTH];
        bus.add_b   = b_q[idx_q*WIDTH +: WIDTH];
        bus.add_cin = carry_q;
        if (cnt_q == CntW'(ADD_LAT)) begin
          result_d[idx_q*WIDTH +: WIDTH] = bus.add_sum;
          carry_d = bus.add_cout;
          cnt_d   = '0;
          if (idx_q == IdxW'(WORDS - 1)) begin
            cout_d  = bus.add_cout;
            idx_d   = '0;
            state_d = StDone;
`ifdef MWAS_SIGNED_OVF_EN
            ovf_d = (a_q[TotW-1] == b_q[TotW-1]) && (bus.add_sum[WIDTH-1] != a_q[TotW-1]);
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
`ifdef MWAS_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
`ifdef MWAS_SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.result   = result_q;
  assign bus.res_cout = cout_q;
`ifdef MWAS_SIGNED_OVF_EN
  assign bus.res_ovf  = ovf_q;
`endif

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Upstream operand sequencer for the `full_half_adder` slice.
- Accepts wide operands (`WORDS*WIDTH` bits), issues them LSW-first one `WIDTH`-bit slice at a time to the adder, and chains each slice's `cout` into the next slice's `cin`.
- Assembles the wide sum and final carry, then presents them on a valid/ready output.
- Lets one narrow adder (combinational or pipelined build) perform arbitrary-width additions.

Parameters:
- `WIDTH`, 4: adder slice width in bits; must match the adder's `WIDTH`.
- `WORDS`, 4: number of slices per operand; ≥ 1.
- `ADD_LAT`, 0: adder result latency in clk cycles (0 = combinational build, 1 = pipelined build); ≥ 0.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `op_a`  in  `WORDS*WIDTH`  operand A.
- `op_b`  in  `WORDS*WIDTH`  operand B.
- `op_cin`  in  1  carry into slice 0.
- `add_a`  out  `WIDTH`  slice of A to adder.
- `add_b`  out  `WIDTH`  slice of B to adder.
- `add_cin`  out  1  chained carry to adder.
- `add_sum`  in  `WIDTH`  adder sum.
- `add_cout`  in  1  adder carry out.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts result.
- `result`  out  `WORDS*WIDTH`  assembled sum.
- `res_cout`  out  1  carry out of top slice.

Behaviour:
- Reset (`rst`=1 at posedge) has priority over everything, including mid-operation. After reset:
  - state=`IDLE`, `in_ready`=1, `res_valid`=0;
  - `result`=0, `res_cout`=0;
  - `add_a`=`add_b`=0, `add_cin`=0;
  - slice index=0, wait counter=0.
  - Any in-flight operation is discarded; no partial result is ever presented.
- States: `IDLE`, `RUN`, `DONE`.
- `IDLE`:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready` at posedge:
    - latch `op_a`, `op_b`;
    - carry register ← `op_cin`;
    - slice index ← 0, wait counter ← 0;
    - go to `RUN`.
  - Operands not accepted in any other state.
- `RUN`:
  - `in_ready`=0.
  - `add_a`/`add_b` = latched operand bits `[idx*WIDTH +: WIDTH]`; `add_cin` = carry register.
  - These three outputs are held stable for the whole slice, which is `ADD_LAT+1` cycles.
  - Wait counter increments each cycle. In the cycle where counter == `ADD_LAT`:
    - capture `add_sum` into `result[idx*WIDTH +: WIDTH]`;
    - carry register ← `add_cout`;
    - counter ← 0, idx ← idx+1.
  - After capturing slice `WORDS-1`: `res_cout` ← `add_cout`, go to `DONE`.
- `DONE`:
  - `res_valid`=1; `result` and `res_cout` held stable.
  - On `res_ready`=1 at posedge: `res_valid`←0, go to `IDLE`.
  - `in_ready` goes high only the cycle after the handshake, so there is no same-cycle result-out/operand-in overlap.
- Latency: if the accept edge ends cycle k, `res_valid` rises in cycle k+1+`WORDS*(ADD_LAT+1)`. Throughput is one operation per `WORDS*(ADD_LAT+1)`+2 cycles minimum.
- In `IDLE` and `DONE`, `add_a`/`add_b`/`add_cin` are driven 0.
- Width rules: all arithmetic is done by the adder; the block only slices and concatenates. `idx` width = `$clog2(WORDS)`, minimum 1. Wait counter width = `$clog2(ADD_LAT+1)`, minimum 1.
- Boundaries:
  - `WORDS`=1: single slice; `res_cout`=`add_cout`.
  - `res_ready` held low: `DONE` persists indefinitely and ignores `in_valid`.
  - `in_valid` dropping after accept has no effect.
  - Carry wrap: all-ones + 1 gives `result`=0, `res_cout`=1.

Optional Feature:
- Macro: `MWAS_SIGNED_OVF_EN`.
- When defined, adds output port `res_ovf` (1 bit): two's-complement overflow of the full-width add, i.e. `(a_msb==b_msb)&&(result_msb!=a_msb)` on the latched operands.
  - Registered with `result`; valid with `res_valid`; reset 0.
- When undefined: the port and its logic do not exist; the block is otherwise identical.

Decomposition:
- Shared package `adder_pkg` holds:
  - state enum typedef (`IDLE`/`RUN`/`DONE`);
  - constants `ADDER_WIDTH_DEF`=4 and `ADDER_LAT_COMB`=0 / `ADDER_LAT_PIPE`=1, shared with `full_half_adder` configuration.
- No sub-module: slice mux, counter and FSM stay in one module.
- Benches pair the block with `full_half_adder` (`WIDTH` matched, pipeline setting matching `ADD_LAT`).

Test Plan:
- Carry ripple (`WIDTH`=4, `WORDS`=4, `ADD_LAT`=0): `op_a`=16'hFFFF, `op_b`=16'h0001, `op_cin`=0 → `result`=16'h0000, `res_cout`=1; `res_valid` rises exactly 5 cycles after accept edge.
- Pipelined adder (`ADD_LAT`=1): `op_a`=16'h1234, `op_b`=16'h4321, `op_cin`=1 → `result`=16'h5556, `res_cout`=0; `res_valid` at accept+9; `add_a`/`add_b` stable for 2 cycles per slice.
- Backpressure: hold `res_ready`=0 for 10 cycles with `in_valid`=1 → `res_valid`, `result` stable, `in_ready`=0; release → `in_ready`=1 the next cycle, second op accepted.
- Reset mid-`RUN`: assert `rst` during slice 2 → next cycle state `IDLE`, `in_ready`=1, `result`=0, `res_valid` never asserted for the aborted op.
- Random: 100 ops, random `op_a`/`op_b`/`op_cin`, random `res_ready` → `{res_cout,result}` == `op_a+op_b+op_cin` every time.
- With `MWAS_SIGNED_OVF_EN`: `op_a`=16'h7FFF, `op_b`=16'h0001 → `res_ovf`=1; 16'hFFFF + 16'h0001 → `res_ovf`=0.
